// File: rtl/dff_pipe_elastic.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing and occupancy count.
// Optional synchronous flush input is compiled in when DFF_PIPE_FLUSH_EN is defined.
module dff_pipe_elastic #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 2,
    parameter int RESET_DATA = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    generate
        if (DEPTH < 1) begin : g_depth_check
            $error("dff_pipe_elastic: DEPTH must be >= 1");
        end
    endgenerate

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] move;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             flush_w;
    logic             accept;
    logic             pop;

`ifdef DFF_PIPE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // A stage advances when it holds data and the next stage is empty or advancing itself.
    always_comb begin
        move = '0;
        move[DEPTH-1] = v_q[DEPTH-1] & out_ready & ~flush_w;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            move[i] = v_q[i] & (~v_q[i+1] | move[i+1]);
        end
    end

    assign in_ready  = (~v_q[0] | move[0]) & ~flush_w;
    assign out_valid = v_q[DEPTH-1] & ~flush_w;
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        v_d    = '0;
        v_d[0] = accept | (v_q[0] & ~move[0]);
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = move[i-1] | (v_q[i] & ~move[i]);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush_w) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    // Data registers only clear on reset when RESET_DATA is set; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_DATA != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
            end
        end else begin
            if (accept) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (move[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

endmodule
